// File: rtl/ha_array_serial_accumulator.sv
// ha_array_serial_accumulator: sequences the four ha_array groups into a saturated 16-bit product
module ha_array_serial_accumulator #(
  parameter int GROUPS = 4,
  parameter int ACC_W  = 17,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       arr_x,
  output logic [7:0]       arr_y,
  input  logic [6:0]       arr_b0,
  input  logic [6:0]       arr_b1,
  input  logic [6:0]       arr_b2,
  input  logic [6:0]       arr_b3,
  input  logic [8:0]       arr_t0,
  input  logic [8:0]       arr_t1,
  input  logic [8:0]       arr_t2,
  input  logic [8:0]       arr_t3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic             out_ovf,
  output logic             busy
);
  localparam int CW = $clog2(GROUPS);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, term, acc_nx;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic [OUT_W-1:0] p_q, p_d;
  logic             ovf_q, ovf_d, ov_q, ov_d;
  logic [6:0]       b_sel;
  logic [8:0]       t_sel;
  assign b_sel  = cnt_q == 2'd0 ? arr_b0 : cnt_q == 2'd1 ? arr_b1 : cnt_q == 2'd2 ? arr_b2 : arr_b3;
  assign t_sel  = cnt_q == 2'd0 ? arr_t0 : cnt_q == 2'd1 ? arr_t1 : cnt_q == 2'd2 ? arr_t2 : arr_t3;
  // sum rows carry weight k, carry rows weight k+2; group i sits at column 2i
  assign term   = (ACC_W'(t_sel) + (ACC_W'(b_sel) << 2)) << {cnt_q, 1'b0};
  assign acc_nx = acc_q + term;
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign arr_x     = x_q;
  assign arr_y     = y_q;
  assign out_p     = p_q;
  assign out_ovf   = ovf_q;
  assign out_valid = ov_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    ov_d    = ov_q;
    if (state_q == IDLE && in_valid) begin
      x_d     = in_x;
      y_d     = in_y;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = ACC;
    end else if (state_q == ACC) begin
      acc_d = acc_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(GROUPS - 1)) begin
        state_d = DONE;
        p_d     = acc_nx > ACC_W'({OUT_W{1'b1}}) ? {OUT_W{1'b1}} : acc_nx[OUT_W-1:0];
        ovf_d   = acc_nx[ACC_W-1];
        ov_d    = 1'b1;
      end
    end else if (state_q == DONE && out_ready) begin
      ov_d    = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_ha_array_serial_accumulator.sv
// tb_ha_array_serial_accumulator: directed scoreboard bench with a stubbed ha_array
module tb_ha_array_serial_accumulator;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, out_valid, out_ovf, busy, in_ready;
  logic [7:0]  in_x, in_y, arr_x, arr_y;
  logic [15:0] out_p;
  logic [6:0]  bb [4];
  logic [8:0]  tt [4];
  logic        sat_mode;
  int          checks = 0;
  int          failures = 0;
  logic [16:0] sb [$];
  always #5 clk = ~clk;
  ha_array_serial_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .arr_x(arr_x), .arr_y(arr_y),
    .arr_b0(bb[0]), .arr_b1(bb[1]), .arr_b2(bb[2]), .arr_b3(bb[3]),
    .arr_t0(tt[0]), .arr_t1(tt[1]), .arr_t2(tt[2]), .arr_t3(tt[3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_ovf(out_ovf), .busy(busy)
  );
  // stub array: exact product split across the four groups, a fixed approximate
  // pattern for 255x255, and all-ones rows in saturation mode
  logic [15:0] pr;
  logic [9:0]  v;
  logic [6:0]  b3e;
  logic [8:0]  t3e;
  assign pr  = arr_x * arr_y;
  assign v   = pr[15:6];
  assign b3e = v > 10'd508 ? 7'd127 : v[8:2];
  assign t3e = 9'(v - {1'b0, b3e, 2'b00});
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bb[i] = 7'd0;
      tt[i] = 9'd0;
    end
    if (sat_mode) begin
      for (int i = 0; i < 4; i++) begin
        bb[i] = 7'h7F;
        tt[i] = 9'h1FF;
      end
    end else if (arr_x == 8'd255 && arr_y == 8'd255) begin
      tt[0] = 9'd1;
      bb[1] = 7'd3;
      bb[3] = 7'd127;
      tt[3] = 9'd490;
    end else begin
      tt[0] = {7'd0, pr[1:0]};
      tt[1] = {7'd0, pr[3:2]};
      tt[2] = {7'd0, pr[5:4]};
      bb[3] = b3e;
      tt[3] = t3e;
    end
  end
  function automatic logic [16:0] exp_of(input logic [7:0] x, input logic [7:0] y);
    if (sat_mode) return 17'h1FFFF;
    if (x == 8'd255 && y == 8'd255) return 17'd63921;
    return {1'b0, 16'(x * y)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 32'd1);
    sb.push_back(exp_of(x, y));
    @(negedge clk);
    in_valid = 1'b0;
    chk("arr_x", {24'd0, arr_x}, {24'd0, x});
    chk("arr_y", {24'd0, arr_y}, {24'd0, y});
  endtask
  task automatic recv(input int hold);
    int n = 0;
    logic [16:0] e;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 4);
    e = sb.size() > 0 ? sb.pop_front() : 17'h0;
    chk("out_p", {16'd0, out_p}, {16'd0, e[15:0]});
    chk("out_ovf", {31'd0, out_ovf}, {31'd0, e[16]});
    for (int c = 0; c < hold; c++) begin
      in_x = 8'd5;
      in_y = 8'd7;
      in_valid = c < 3;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_p", {16'd0, out_p}, {16'd0, e[15:0]});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    if (hold > 0) chk("hold_arr_x", {24'd0, arr_x}, 32'd255);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("keep_p", {16'd0, out_p}, {16'd0, e[15:0]});
  endtask
  initial begin
    int acc_t [$];
    int outs, c;
    logic [16:0] e;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = 8'd0;
    in_y = 8'd0;
    sat_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_p", {15'd0, out_ovf, out_p}, 32'd0);
    chk("rst_arr", {16'd0, arr_x, arr_y}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd1, 8'd1);
    chk("busy_acc", {31'd0, busy}, 32'd1);
    recv(0);
    send(8'd255, 8'd255);
    recv(10);
    sat_mode = 1'b1;
    send(8'd9, 8'd9);
    recv(0);
    sat_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom_range(0, 254)), 8'($urandom_range(0, 254)));
      recv(0);
    end
    send(8'd3, 8'd4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_p", {15'd0, out_ovf, out_p}, 32'd0);
    chk("mid_rst_arr", {16'd0, arr_x, arr_y}, 32'd0);
    outs = 0;
    repeat (6) begin
      @(negedge clk);
      outs += out_valid;
    end
    chk("no_out_after_rst", outs, 0);
    in_x = 8'd0;
    in_y = 8'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    outs = 0;
    c = 0;
    while (outs < 2 && c < 40) begin
      if (in_valid && in_ready) begin
        acc_t.push_back(c);
        sb.push_back(exp_of(in_x, in_y));
      end
      if (out_valid && out_ready) begin
        e = sb.size() > 0 ? sb.pop_front() : 17'h1_5555;
        chk("b2b_out", {15'd0, out_ovf, out_p}, {15'd0, e});
        outs++;
      end
      @(negedge clk);
      c++;
      if (acc_t.size() == 1) begin
        in_x = 8'd1;
        in_y = 8'd1;
      end else if (acc_t.size() >= 2) in_valid = 1'b0;
    end
    chk("b2b_outs", outs, 2);
    chk("b2b_spacing", acc_t.size() >= 2 ? acc_t[1] - acc_t[0] : -1, 6);
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
